// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and counter width for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority search: first set bit of valid at or above start, with wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  always_comb begin
    doubled = {valid, valid};
    // bit k of rotated is requester (start + k) mod N
    rotated = doubled[start +: N];
    found   = |rotated;
    offset  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IW'(k);
    end
    sum   = {1'b0, start} + {1'b0, offset};
    index = (sum >= N_EXT) ? IW'(sum - N_EXT) : sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
// Optional per-requester word counters: define FIFO_ARB_STATS_EN.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [NUM_REQ*16-1:0]         stat_words
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_B  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] IDLE_T = CNT_W'(IDLE_TIMEOUT);
  localparam logic [IW-1:0]    LAST_REQ = IW'(NUM_REQ - 1);

  arb_state_e       state, state_nx;
  logic [IW-1:0]    last_owner;
  logic [IW-1:0]    search_start;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             owner_valid;
  logic             owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic             accept;
  logic             burst_done;
  logic             stall_done;

  assign search_start = (last_owner == LAST_REQ) ? '0 : last_owner + 1'b1;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .valid (req_valid),
    .start (search_start),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // fifo_full stalls keep owner_valid high, so they never advance the stall counter
  assign accept     = (state == GRANT) && owner_valid && !fifo_full;
  assign burst_done = accept && (owner_last || (burst_cnt + 1'b1 == MAX_B));
  assign stall_done = (state == GRANT) && !owner_valid && (stall_cnt + 1'b1 == IDLE_T);

  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = accept;
    fifo_wr_data = owner_data;
    case (state)
      IDLE: begin
        if (pick_found) state_nx = GRANT;
      end
      GRANT: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id == IW'(i)) && !fifo_full;
        end
        if (burst_done || stall_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= LAST_REQ;
      grant_id   <= '0;
      burst_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            stall_cnt <= '0;
          end
        end
        GRANT: begin
          if (accept) burst_cnt <= burst_cnt + 1'b1;
          if (owner_valid) stall_cnt <= '0;
          else             stall_cnt <= stall_cnt + 1'b1;
          if (state_nx == IDLE) last_owner <= grant_id;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [15:0] word_cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_cnt <= '0;
      end else if (accept && (grant_id == IW'(i)) && (word_cnt != 16'hFFFF)) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
    assign stat_words[i*16 +: 16] = word_cnt;
  end
`else
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic [1:0]        grant_id;
  logic              busy;
  logic [NR*16-1:0]  stat_words;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] wq[NR][$];
  bit            lq[NR][$];
  int            obs_id[$];
  logic [DW-1:0] obs_d[$];
  int            obs_cyc[$];
  bit            busy_log[$];
  int            ready_bad;

  fifo_write_arbiter #(
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy),
    .stat_words   (stat_words)
  );

  always #5 clk = ~clk;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += wq[i].size();
    return s;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      wq[i].delete();
      lq[i].delete();
    end
    obs_id.delete();
    obs_d.delete();
    obs_cyc.delete();
    busy_log.delete();
    ready_bad = 0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_all();
  endtask

  task automatic push_words(input int r, input int n, input int last_at);
    for (int j = 0; j < n; j++) begin
      wq[r].push_back(DW'($urandom));
      lq[r].push_back(j == last_at);
    end
  endtask

  // Drives queue heads each negedge, samples outputs 1 time unit later, pops on handshake.
  task automatic run(input int ncyc, input logic [63:0] full_mask, input int full_pct,
                     input bit stop_empty);
    logic [NR-1:0] exp_ready;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (wq[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = wq[i][0];
          req_last[i]           = lq[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      fifo_full = ((c < 64) ? full_mask[c] : 1'b0) || (int'($urandom_range(99)) < full_pct);
      #1;
      busy_log.push_back(busy);
      exp_ready = (busy && !fifo_full) ? (4'b0001 << grant_id) : 4'b0000;
      if (req_ready !== exp_ready) ready_bad++;
      if (fifo_wr_en === 1'b1) begin
        obs_id.push_back(int'(grant_id));
        obs_d.push_back(fifo_wr_data);
        obs_cyc.push_back(c);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i] === 1'b1) begin
          void'(wq[i].pop_front());
          void'(lq[i].pop_front());
        end
      end
      if (stop_empty && pending() == 0) break;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_state busy=%b grant_id=%0d required busy=0 grant_id=0", busy, grant_id);
    end
    tests++;
    if (req_ready !== 4'b0 || fifo_wr_en !== 1'b0 || stat_words !== '0) begin
      fails++;
      $display("FAIL reset_outputs ready=%b wr_en=%b stat=%h required 0", req_ready, fifo_wr_en,
               stat_words);
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] exp_d[$];
    do_reset();
    push_words(0, 3, 2);
    exp_d = wq[0];
    run(6, 64'h0, 0, 0);
    tests++;
    if (obs_id.size() != 3) begin
      fails++;
      $display("FAIL single_count writes=%0d required 3", obs_id.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_id[k] != 0 || obs_d[k] !== exp_d[k]) begin
          fails++;
          $display("FAIL single_word%0d id=%0d data=%h required id=0 data=%h", k, obs_id[k],
                   obs_d[k], exp_d[k]);
        end
      end
      tests++;
      if (busy_log[obs_cyc[2] + 1] !== 1'b0 || busy_log[obs_cyc[2]] !== 1'b1) begin
        fails++;
        $display("FAIL single_release busy_after=%b busy_on_last=%b required 0,1",
                 busy_log[obs_cyc[2] + 1], busy_log[obs_cyc[2]]);
      end
    end
    tests++;
    if (grant_id !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle_hold grant_id=%0d busy=%b required 0,0", grant_id, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_d[NR][$];
    int g, id, gap_req, bad;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      push_words(i, 2 * MB, -1);
      exp_d[i] = wq[i];
    end
    run(120, 64'h0, 0, 1);
    tests++;
    if (obs_id.size() != 8 * MB || pending() != 0) begin
      fails++;
      $display("FAIL rr_count writes=%0d left=%0d required %0d,0", obs_id.size(), pending(), 8 * MB);
    end else begin
      bad = 0;
      for (int k = 0; k < 8 * MB && bad == 0; k++) begin
        g  = k / MB;
        id = g % NR;
        gap_req = (k % MB == 0) ? 2 : 1;
        tests++;
        if (obs_id[k] != id || obs_d[k] !== exp_d[id][(g / NR) * MB + k % MB]) begin
          fails++; bad = 1;
          $display("FAIL rr_order word%0d id=%0d required id=%0d", k, obs_id[k], id);
        end
        if (k > 0) begin
          tests++;
          if (obs_cyc[k] - obs_cyc[k-1] != gap_req) begin
            fails++; bad = 1;
            $display("FAIL rr_gap word%0d gap=%0d required %0d", k, obs_cyc[k] - obs_cyc[k-1],
                     gap_req);
          end
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] exp_d[$];
    do_reset();
    push_words(1, 6, 5);
    exp_d = wq[1];
    run(16, 64'h1F0, 0, 1);
    tests++;
    if (obs_id.size() != 6) begin
      fails++;
      $display("FAIL full_count writes=%0d required 6", obs_id.size());
    end else begin
      tests++;
      if (obs_cyc[2] != 3 || obs_cyc[3] != 9 || obs_cyc[5] != 11) begin
        fails++;
        $display("FAIL full_timing cycles=%0d,%0d,%0d required 3,9,11", obs_cyc[2], obs_cyc[3],
                 obs_cyc[5]);
      end
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (obs_id[k] != 1 || obs_d[k] !== exp_d[k]) begin
          fails++;
          $display("FAIL full_word%0d id=%0d data=%h required id=1 data=%h", k, obs_id[k],
                   obs_d[k], exp_d[k]);
        end
      end
    end
    tests++;
    if (busy_log[4] !== 1'b1 || busy_log[8] !== 1'b1 || ready_bad != 0) begin
      fails++;
      $display("FAIL full_hold busy4=%b busy8=%b ready_errs=%0d required 1,1,0", busy_log[4],
               busy_log[8], ready_bad);
    end
  endtask

  task automatic test_stall_timeout();
    do_reset();
    push_words(2, 2, -1);
    push_words(3, 1, 0);
    run(40, 64'h0, 0, 1);
    tests++;
    if (busy_log.size() < 21 || busy_log[18] !== 1'b1 || busy_log[19] !== 1'b0) begin
      fails++;
      $display("FAIL stall_release cycles_logged=%0d required busy 1 at cycle 18, 0 at 19",
               busy_log.size());
    end
    tests++;
    if (obs_id.size() != 3 || obs_id[0] != 2 || obs_id[2] != 3 || obs_cyc[2] != 20) begin
      fails++;
      $display("FAIL stall_next writes=%0d required 3 with requester 3 written at cycle 20",
               obs_id.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push_words(0, 8, 7);
    run(4, 64'h0, 0, 0);
    @(negedge clk);
    req_valid[0]       = 1'b1;
    req_data[0 +: DW]  = wq[0][0];
    req_last[0]        = 1'b0;
    #1;
    tests++;
    if (fifo_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre wr_en=%b required 1", fifo_wr_en);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || req_ready !== 4'b0 || fifo_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL midreset_drop busy=%b ready=%b wr_en=%b required 0", busy, req_ready,
               fifo_wr_en);
    end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    clear_all();
    push_words(1, 1, 0);
    push_words(0, 1, 0);
    run(8, 64'h0, 0, 1);
    tests++;
    if (obs_id.size() != 2 || obs_id[0] != 0 || obs_id[1] != 1) begin
      fails++;
      $display("FAIL midreset_next writes=%0d first_id=%0d required 2 writes, first id 0",
               obs_id.size(), (obs_id.size() > 0) ? obs_id[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] cd[NR][$];
    bit            cl[NR][$];
    int            ex_id[$];
    logic [DW-1:0] ex_d[$];
    int            m_last, c, n, bad;
    bit            lf;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      n = $urandom_range(4, 20);
      for (int j = 0; j < n; j++) begin
        wq[i].push_back(DW'($urandom));
        lq[i].push_back((j == n - 1) || ($urandom_range(3) == 0));
      end
      cd[i] = wq[i];
      cl[i] = lq[i];
    end
    // Expected write order: round-robin over requesters with words left, bursts end on last or MB.
    m_last = NR - 1;
    while (cd[0].size() + cd[1].size() + cd[2].size() + cd[3].size() > 0) begin
      c = -1;
      for (int k = 1; k <= NR; k++) begin
        if (c < 0 && cd[(m_last + k) % NR].size() > 0) c = (m_last + k) % NR;
      end
      n  = 0;
      lf = 1'b0;
      while (!lf && n < MB) begin
        ex_id.push_back(c);
        ex_d.push_back(cd[c].pop_front());
        lf = cl[c].pop_front();
        n++;
      end
      m_last = c;
    end
    run(3000, 64'h0, 30, 1);
    tests++;
    if (pending() != 0 || obs_id.size() != ex_id.size()) begin
      fails++;
      $display("FAIL rand_count writes=%0d left=%0d required %0d,0", obs_id.size(), pending(),
               ex_id.size());
    end else begin
      bad = 0;
      for (int k = 0; k < ex_id.size() && bad == 0; k++) begin
        tests++;
        if (obs_id[k] != ex_id[k] || obs_d[k] !== ex_d[k]) begin
          fails++; bad = 1;
          $display("FAIL rand_word%0d id=%0d data=%h required id=%0d data=%h", k, obs_id[k],
                   obs_d[k], ex_id[k], ex_d[k]);
        end
      end
    end
    tests++;
    if (ready_bad != 0) begin
      fails++;
      $display("FAIL rand_ready bad_cycles=%0d required 0", ready_bad);
    end
  endtask

  task automatic test_stats();
`ifdef FIFO_ARB_STATS_EN
    do_reset();
    push_words(2, 70000, 69999);
    run(80000, 64'h0, 0, 1);
    tests++;
    if (stat_words[2*16 +: 16] !== 16'hFFFF || stat_words[0 +: 32] !== 32'h0 ||
        stat_words[3*16 +: 16] !== 16'h0) begin
      fails++;
      $display("FAIL stats_saturate stat=%h required 0000ffff00000000", stat_words);
    end
`else
    do_reset();
    push_words(2, 20, 19);
    push_words(0, 5, 4);
    run(60, 64'h0, 0, 1);
    tests++;
    if (stat_words !== '0 || obs_id.size() != 25) begin
      fails++;
      $display("FAIL stats_tied stat=%h writes=%0d required 0,25", stat_words, obs_id.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_fifo_full();
    test_stall_timeout();
    test_reset_mid_burst();
    for (int r = 0; r < 4; r++) test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter DATA_WIDTH SHALL default to 16 and set the word width.
REQ-003 Parameter NUM_REQ SHALL default to 4 and set the requester count (2..8).
REQ-004 Parameter MAX_BURST SHALL default to 8 and set the maximum words per grant (1..255).
REQ-005 Parameter IDLE_TIMEOUT SHALL default to 16 and set the stall cycles before forced release (1..255).
REQ-006 Ports SHALL be as follows:
- clk  in  1  clock
- reset  in  1  async active-high reset
- req_valid  in  NUM_REQ  requester has a word
- req_data  in  NUM_REQ*DATA_WIDTH  requester words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  word ends requester's burst
- req_ready  out  NUM_REQ  word accepted this cycle when valid&ready
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- fifo_full  in  1  FIFO cannot accept
- grant_id  out  $clog2(NUM_REQ)  current owner
- busy  out  1  a grant is held
- stat_words  out  NUM_REQ*16  per-requester accepted-word counters

Function
REQ-007 The FSM SHALL have states IDLE and GRANT.
REQ-008 In IDLE with any req_valid set, the block SHALL grant the first valid requester searching upward, with wrap, from (last_owner+1) mod NUM_REQ, then enter GRANT next cycle.
REQ-009 In IDLE with no req_valid set, the block SHALL stay in IDLE.
REQ-010 In GRANT, req_ready[grant_id] SHALL equal !fifo_full, and all other req_ready bits SHALL be 0.
REQ-011 fifo_wr_en SHALL equal req_valid[grant_id] & req_ready[grant_id] (combinational, zero latency), and fifo_wr_data SHALL equal req_data of grant_id.
REQ-012 Each accepted word SHALL increment burst_cnt (8-bit), which clears on entering GRANT.
REQ-013 The grant SHALL be released (GRANT->IDLE, last_owner<=grant_id) on an accepted word with req_last set, or on the accepted word that makes burst_cnt reach MAX_BURST.
REQ-014 stall_cnt SHALL count consecutive GRANT cycles with req_valid[grant_id]=0, SHALL clear on any cycle with it set, and SHALL force release on reaching IDLE_TIMEOUT; fifo_full-only stalls SHALL NOT count.
REQ-015 Release SHALL cost exactly one IDLE cycle before the next grant (peak throughput MAX_BURST/(MAX_BURST+1)).
REQ-016 busy SHALL be 1 exactly in GRANT, and grant_id SHALL hold its value in IDLE.
REQ-017 In IDLE, all req_ready bits and fifo_wr_en SHALL be 0.

Reset
REQ-018 Reset SHALL force state IDLE, last_owner=NUM_REQ-1 (first search starts at 0), grant_id=0, burst_cnt=0, stall_cnt=0, stat_words=0.
REQ-019 Reset asserted mid-burst SHALL drop busy, req_ready and fifo_wr_en to 0 immediately (asynchronously), with no partial-word write.

Configuration
REQ-020 With macro FIFO_ARB_STATS_EN defined, stat_words[i] SHALL increment on each word accepted from requester i, saturating at 16'hFFFF.
REQ-021 Without FIFO_ARB_STATS_EN, stat_words SHALL be present and tied to 0, and no counter registers SHALL be built.

Structure
REQ-022 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the burst/stall counter width constant (8).
REQ-023 Sub-module rr_pick SHALL contain the combinational rotate-priority search (inputs: valid vector, start index; outputs: found, index).

Verification
REQ-024 Reset, then req_valid=4'b0001, 3 words with last on the 3rd: grant_id=0, 3 fifo_wr_en pulses, busy=0 on the cycle after the 3rd word.
REQ-025 All four requesters valid, no req_last, MAX_BURST=8: grant order 0,1,2,3,0, 8 words each, one idle cycle between grants.
REQ-026 fifo_full=1 for 5 cycles mid-burst: req_ready=0 and no writes, no timeout, and the burst resumes with the count intact.
REQ-027 Owner drops valid for 16 cycles: forced release after the 16th cycle, and the next valid requester is granted.
REQ-028 Reset asserted on the 4th word of a burst: outputs return to 0 the same cycle, and the next grant goes to requester 0.
REQ-029 With FIFO_ARB_STATS_EN, 70000 words from requester 2: stat_words[2] reads 16'hFFFF and the other counters read 0.
